// File: rtl/rv_pkg.sv
// Shared constants and helpers for the integer register file slice of the
// 5-stage RISC-V pipeline.
package rv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  // Address width for a register file of nreg entries, never narrower than one bit.
  function automatic int reg_aw(input int nreg);
    return (nreg > 2) ? $clog2(nreg) : 1;
  endfunction

  typedef logic [$clog2(NREG_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits used by decode for hazard stalls; set has priority
// over a same-cycle clear, and x0 is never busy.
module rf_scoreboard
  import rv_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = reg_aw(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sb_set_en,
  input  logic [AW-1:0]     sb_set_addr,
  input  logic [NWR-1:0]    sb_clr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] set_s;
  logic [NREG-1:0] clr_s;
  logic [NREG-1:0] busy_nxt_s;

  // Decode set/clear strobes per register and form the next busy vector.
  always_comb begin
    set_s      = '0;
    clr_s      = '0;
    busy_nxt_s = '0;
    for (int r = 1; r < NREG; r++) begin
      set_s[r] = sb_set_en && (sb_set_addr == AW'(r));
      for (int k = 0; k < NWR; k++) begin
        if (sb_clr_en[k] && (wr_addr[k*AW +: AW] == AW'(r))) begin
          clr_s[r] = 1'b1;
        end else begin
          clr_s[r] = clr_s[r];
        end
      end
      busy_nxt_s[r] = set_s[r] | (busy_r[r] & ~clr_s[r]);
    end
  end

  // Busy state register; reset drops every pending producer.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Busy lookup; a retiring producer is hidden when forwarding is enabled.
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = busy_r[rd_addr[i*AW +: AW]] &
                   ~((BYPASS != 0) & clr_s[rd_addr[i*AW +: AW]] & ~set_s[rd_addr[i*AW +: AW]]);
    end
  end

endmodule

// File: rtl/id_regfile_mp.sv
// Multi-port ID-stage integer register file: clocked writes with highest-port
// priority, combinational reads with optional write forwarding, busy scoreboard.
module id_regfile_mp
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = reg_aw(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  input  logic [NWR-1:0]      sb_clr_en
);

  if ((NWR < 1) || (NWR > 4) || (NRD < 1) || (NREG < 2) ||
      ((NREG & (NREG - 1)) != 0)) begin : g_bad_param
    $error("id_regfile_mp: illegal NWR/NRD/NREG configuration");
  end

  logic [XLEN-1:0] mem_r    [NREG];
  logic [XLEN-1:0] wr_val_s [NREG];
  logic [NREG-1:0] wr_hit_s;

  // Resolve write ports per register; later ports override earlier ones.
  always_comb begin
    wr_hit_s    = '0;
    wr_val_s[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      wr_val_s[r] = mem_r[r];
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] == AW'(r))) begin
          wr_hit_s[r] = 1'b1;
          wr_val_s[r] = wr_data[k*XLEN +: XLEN];
        end else begin
          wr_hit_s[r] = wr_hit_s[r];
          wr_val_s[r] = wr_val_s[r];
        end
      end
    end
  end

  // Storage array; x0 is held at zero because its resolved value is constant.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) mem_r[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) mem_r[r] <= wr_val_s[r];
    end
  end

  // Read mux with optional same-cycle forwarding of the winning write.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if ((BYPASS != 0) && wr_hit_s[rd_addr[i*AW +: AW]]) begin
        rd_data[i*XLEN +: XLEN] = wr_val_s[rd_addr[i*AW +: AW]];
      end else begin
        rd_data[i*XLEN +: XLEN] = mem_r[rd_addr[i*AW +: AW]];
      end
    end
  end

  rf_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .NWR    (NWR),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_clr_en   (sb_clr_en),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy)
  );

endmodule

// File: tb/tb_id_regfile_mp.sv
// Directed vector table plus hand sequences and a reference-model random run
// for id_regfile_mp (NWR=2/BYPASS=1 and NWR=1/BYPASS=0 builds).
module tb_id_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic [2*AW-1:0]   rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]        rd_busy;
  logic              sb_set_en;
  logic [AW-1:0]     sb_set_addr;
  logic [1:0]        sb_clr_en;

  logic [0:0]      nb_wr_en;
  logic [AW-1:0]   nb_wr_addr;
  logic [XLEN-1:0] nb_wr_data;
  logic [AW-1:0]   nb_rd_addr;
  logic [XLEN-1:0] nb_rd_data;
  logic [0:0]      nb_rd_busy;
  logic            nb_sb_set_en;
  logic [AW-1:0]   nb_sb_set_addr;
  logic [0:0]      nb_sb_clr_en;

  id_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(2), .NWR(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_clr_en(sb_clr_en)
  );

  id_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(1), .NWR(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data),
    .rd_addr(nb_rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .sb_set_en(nb_sb_set_en), .sb_set_addr(nb_sb_set_addr), .sb_clr_en(nb_sb_clr_en)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic        se;
    logic [4:0]  sa;
    logic [1:0]  ce;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs [22];

  logic [31:0] m_mem  [NREG];
  logic        m_busy [NREG];

  task automatic nb_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] ra, input logic se, input logic [4:0] sa,
                          input logic ce, input logic [31:0] ed, input logic eb, input string nm);
    @(negedge clk);
    nb_wr_en = we; nb_wr_addr = wa; nb_wr_data = wd; nb_rd_addr = ra;
    nb_sb_set_en = se; nb_sb_set_addr = sa; nb_sb_clr_en = ce;
    #2;
    check({nm, "_data"}, 64'(nb_rd_data), 64'(ed));
    check({nm, "_busy"}, 64'(nb_rd_busy), 64'(eb));
  endtask

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    logic        b, clr, setx;
    logic [63:0] exp_d;
    logic [1:0]  exp_b;
    int          lim;

    //           rst   we     wa0    wa1    wd0            wd1           ra0     ra1    se    sa      ce     e0             e1            eb
    vecs[0]  = '{1'b0, 2'b01, 5'd5,  5'd0,  32'h1234,      32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  2'b00, 32'h1234,      32'h0,        2'b00};
    vecs[1]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd5,  5'd5,  1'b0, 5'd0,  2'b00, 32'h1234,      32'h1234,     2'b00};
    vecs[2]  = '{1'b1, 2'b01, 5'd6,  5'd0,  32'h99,        32'h0,        5'd5,  5'd5,  1'b1, 5'd6,  2'b00, 32'h1234,      32'h1234,     2'b00};
    vecs[3]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd5,  5'd6,  1'b0, 5'd0,  2'b00, 32'h0,         32'h0,        2'b00};
    vecs[4]  = '{1'b0, 2'b01, 5'd0,  5'd0,  32'hFFFFFFFF,  32'h0,        5'd0,  5'd0,  1'b1, 5'd0,  2'b00, 32'h0,         32'h0,        2'b00};
    vecs[5]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd0,  5'd0,  1'b0, 5'd0,  2'b01, 32'h0,         32'h0,        2'b00};
    vecs[6]  = '{1'b0, 2'b11, 5'd7,  5'd7,  32'hAAAA,      32'h5555,     5'd7,  5'd7,  1'b0, 5'd0,  2'b00, 32'h5555,      32'h5555,     2'b00};
    vecs[7]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd7,  5'd0,  1'b0, 5'd0,  2'b00, 32'h5555,      32'h0,        2'b00};
    vecs[8]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd9,  5'd0,  1'b1, 5'd9,  2'b00, 32'h0,         32'h0,        2'b00};
    vecs[9]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd9,  5'd9,  1'b0, 5'd0,  2'b00, 32'h0,         32'h0,        2'b11};
    vecs[10] = '{1'b0, 2'b01, 5'd9,  5'd0,  32'hCAFE,      32'h0,        5'd9,  5'd7,  1'b0, 5'd0,  2'b01, 32'hCAFE,      32'h5555,     2'b00};
    vecs[11] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd9,  5'd9,  1'b0, 5'd0,  2'b00, 32'hCAFE,      32'hCAFE,     2'b00};
    vecs[12] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd4,  5'd0,  1'b1, 5'd4,  2'b00, 32'h0,         32'h0,        2'b00};
    vecs[13] = '{1'b0, 2'b10, 5'd0,  5'd4,  32'h0,         32'h44,       5'd4,  5'd4,  1'b1, 5'd4,  2'b10, 32'h44,        32'h44,       2'b11};
    vecs[14] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd4,  5'd0,  1'b0, 5'd0,  2'b00, 32'h44,        32'h0,        2'b01};
    vecs[15] = '{1'b0, 2'b00, 5'd0,  5'd4,  32'h0,         32'h0,        5'd4,  5'd4,  1'b0, 5'd0,  2'b10, 32'h44,        32'h44,       2'b00};
    vecs[16] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd4,  5'd9,  1'b0, 5'd0,  2'b00, 32'h44,        32'hCAFE,     2'b00};
    vecs[17] = '{1'b0, 2'b11, 5'd3,  5'd8,  32'h33,        32'h88,       5'd3,  5'd8,  1'b0, 5'd0,  2'b00, 32'h33,        32'h88,       2'b00};
    vecs[18] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd3,  5'd8,  1'b0, 5'd0,  2'b00, 32'h33,        32'h88,       2'b00};
    vecs[19] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd10, 5'd3,  1'b1, 5'd10, 2'b00, 32'h0,         32'h33,       2'b00};
    vecs[20] = '{1'b1, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd10, 5'd3,  1'b0, 5'd0,  2'b00, 32'h0,         32'h33,       2'b01};
    vecs[21] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,         32'h0,        5'd10, 5'd3,  1'b0, 5'd0,  2'b00, 32'h0,         32'h0,        2'b00};

    rst = 1'b1;
    wr_en = 2'b00; wr_addr = '0; wr_data = '0; rd_addr = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; sb_clr_en = 2'b00;
    nb_wr_en = 1'b0; nb_wr_addr = '0; nb_wr_data = '0; nb_rd_addr = '0;
    nb_sb_set_en = 1'b0; nb_sb_set_addr = '0; nb_sb_clr_en = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 22; v++) begin
      @(negedge clk);
      rst = vecs[v].rst;
      wr_en = vecs[v].we;
      wr_addr = {vecs[v].wa1, vecs[v].wa0};
      wr_data = {vecs[v].wd1, vecs[v].wd0};
      rd_addr = {vecs[v].ra1, vecs[v].ra0};
      sb_set_en = vecs[v].se;
      sb_set_addr = vecs[v].sa;
      sb_clr_en = vecs[v].ce;
      #2;
      check($sformatf("vec%0d_rd0", v), 64'(rd_data[31:0]), 64'(vecs[v].e0));
      check($sformatf("vec%0d_rd1", v), 64'(rd_data[63:32]), 64'(vecs[v].e1));
      check($sformatf("vec%0d_busy", v), 64'(rd_busy), 64'(vecs[v].eb));
    end

    @(negedge clk);
    rst = 1'b0; wr_en = 2'b00; rd_addr = '0; sb_set_en = 1'b0; sb_clr_en = 2'b00;

    // Non-forwarding build: new data and cleared busy appear one cycle later.
    nb_cycle(1'b1, 5'd3, 32'h10, 5'd3, 1'b0, 5'd0, 1'b0, 32'h0,  1'b0, "nb_wr_same");
    nb_cycle(1'b0, 5'd0, 32'h0,  5'd3, 1'b0, 5'd0, 1'b0, 32'h10, 1'b0, "nb_wr_next");
    nb_cycle(1'b0, 5'd0, 32'h0,  5'd2, 1'b1, 5'd2, 1'b0, 32'h0,  1'b0, "nb_set");
    nb_cycle(1'b1, 5'd2, 32'h22, 5'd2, 1'b0, 5'd0, 1'b1, 32'h0,  1'b1, "nb_clr_same");
    nb_cycle(1'b0, 5'd0, 32'h0,  5'd2, 1'b0, 5'd0, 1'b0, 32'h22, 1'b0, "nb_clr_next");

    for (int r = 0; r < NREG; r++) begin
      m_mem[r] = 32'h0;
      m_busy[r] = 1'b0;
    end

    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      lim = ((c % 4) == 0) ? 31 : 7;
      rst = ($urandom_range(0, 499) == 0);
      wr_en = 2'($urandom);
      wr_addr = {5'($urandom_range(0, lim)), 5'($urandom_range(0, lim))};
      wr_data = {$urandom, $urandom};
      rd_addr = {5'($urandom_range(0, lim)), 5'($urandom_range(0, lim))};
      sb_set_en = 1'($urandom);
      sb_set_addr = 5'($urandom_range(0, lim));
      sb_clr_en = 2'($urandom);
      #2;
      for (int i = 0; i < 2; i++) begin
        a = rd_addr[i*AW +: AW];
        d = m_mem[a];
        b = m_busy[a];
        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
          if (wr_en[k] && (wr_addr[k*AW +: AW] == a)) d = wr_data[k*XLEN +: XLEN];
          if (sb_clr_en[k] && (wr_addr[k*AW +: AW] == a)) clr = 1'b1;
        end
        setx = sb_set_en && (sb_set_addr == a);
        if (clr && !setx) b = 1'b0;
        if (a == 5'd0) begin
          d = 32'h0;
          b = 1'b0;
        end
        exp_d[i*XLEN +: XLEN] = d;
        exp_b[i] = b;
      end
      check("rand_rd_data", rd_data, exp_d);
      check("rand_rd_busy", 64'(rd_busy), 64'(exp_b));
      if (rst) begin
        for (int r = 0; r < NREG; r++) begin
          m_mem[r] = 32'h0;
          m_busy[r] = 1'b0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (wr_en[k] && (wr_addr[k*AW +: AW] != 5'd0)) m_mem[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
          if (sb_clr_en[k]) m_busy[wr_addr[k*AW +: AW]] = 1'b0;
        end
        if (sb_set_en && (sb_set_addr != 5'd0)) m_busy[sb_set_addr] = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
